// File: rtl/pcpi_crc32_pkg.sv
// Shared encodings, FSM state type and decode helper for the PCPI CRC32 responder.
package pcpi_crc32_pkg;

  localparam logic [6:0]  OPC_CUSTOM0          = 7'b0001011;
  localparam logic [6:0]  FUNCT7_CRC           = 7'b0000000;
  localparam logic [2:0]  FUNCT3_CRC_B         = 3'b000;
  localparam logic [2:0]  FUNCT3_CRC_H         = 3'b001;
  localparam logic [2:0]  FUNCT3_CRC_W         = 3'b010;
  localparam logic [31:0] CRC32_POLY_REFLECTED = 32'hEDB88320;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  // Number of data bits consumed by an encoding; 0 marks an encoding we do not claim.
  function automatic logic [5:0] crc_nbits(input logic [2:0] funct3);
    case (funct3)
      FUNCT3_CRC_B: crc_nbits = 6'd8;
      FUNCT3_CRC_H: crc_nbits = 6'd16;
      FUNCT3_CRC_W: crc_nbits = 6'd32;
      default:      crc_nbits = 6'd0;
    endcase
  endfunction

endpackage

// File: rtl/crc32_bit_step.sv
// Combinational chain of BITS_PER_CYCLE reflected CRC32 bit steps, data consumed LSB first.
module crc32_bit_step #(
  parameter logic [31:0] POLY           = 32'hEDB88320,
  parameter int          BITS_PER_CYCLE = 1
) (
  input  logic [31:0]               crc,
  input  logic [BITS_PER_CYCLE-1:0] data,
  output logic [31:0]               crc_next
);

  generate
    for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_step
      logic [31:0] c_in;
      logic [31:0] c_out;
      logic        fb;
      if (gi == 0) begin : g_first
        assign c_in = crc;
      end else begin : g_chain
        assign c_in = g_step[gi-1].c_out;
      end
      assign fb    = c_in[0] ^ data[gi];
      assign c_out = (c_in >> 1) ^ (fb ? POLY : 32'h0);
    end
  endgenerate

  assign crc_next = g_step[BITS_PER_CYCLE-1].c_out;

endmodule

// File: rtl/pcpi_crc32.sv
// PCPI co-processor executing custom-0 CRC32 byte/half/word update instructions,
// bit-serial with BITS_PER_CYCLE bits per BUSY cycle and fully registered outputs.
module pcpi_crc32
  import pcpi_crc32_pkg::*;
#(
  parameter logic [31:0] POLY           = CRC32_POLY_REFLECTED,
  parameter int          BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  input  logic [31:0] pcpi_rs1,
  input  logic [31:0] pcpi_rs2,
  output logic        pcpi_wr,
  output logic [31:0] pcpi_rd,
  output logic        pcpi_wait,
  output logic        pcpi_ready
);

  localparam int STEP_SHIFT = $clog2(BITS_PER_CYCLE);

  state_t      state_reg, state_next;
  logic [31:0] crc_reg;
  logic [31:0] data_reg;
  logic [5:0]  cnt_reg;

  logic [5:0]  insn_nbits;
  logic        insn_match;
  logic        accept;
  logic        advance;
  logic [31:0] step_crc;

  always_comb begin
    insn_nbits = crc_nbits(pcpi_insn[14:12]);
    insn_match = (pcpi_insn[6:0] == OPC_CUSTOM0) &&
                 (pcpi_insn[31:25] == FUNCT7_CRC) &&
                 (insn_nbits != 6'd0);
    accept     = (state_reg == IDLE) && pcpi_valid && insn_match;
    advance    = (state_reg == BUSY) && pcpi_valid;
  end

  crc32_bit_step #(
    .POLY          (POLY),
    .BITS_PER_CYCLE(BITS_PER_CYCLE)
  ) u_step (
    .crc     (crc_reg),
    .data    (data_reg[BITS_PER_CYCLE-1:0]),
    .crc_next(step_crc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Dropping pcpi_valid while busy abandons the instruction without a ready pulse.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = BUSY;
      BUSY: begin
        if (!pcpi_valid) begin
          state_next = IDLE;
        end else if (cnt_reg == 6'd1) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crc_reg  <= 32'h0;
      data_reg <= 32'h0;
      cnt_reg  <= 6'd0;
    end else if (accept) begin
      crc_reg  <= pcpi_rs1;
      data_reg <= pcpi_rs2;
      cnt_reg  <= insn_nbits >> STEP_SHIFT;
    end else if (advance) begin
      crc_reg  <= step_crc;
      data_reg <= data_reg >> BITS_PER_CYCLE;
      cnt_reg  <= cnt_reg - 6'd1;
    end
  end

  // Outputs are registered from the next state, so they line up with state_reg.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcpi_wait  <= 1'b0;
      pcpi_ready <= 1'b0;
      pcpi_wr    <= 1'b0;
      pcpi_rd    <= 32'h0;
    end else begin
      pcpi_wait  <= (state_next == BUSY);
      pcpi_ready <= (state_next == DONE);
      pcpi_wr    <= (state_next == DONE);
      pcpi_rd    <= (state_next == DONE) ? step_crc : 32'h0;
    end
  end

endmodule

// File: doc/pcpi_crc32.md
Name: pcpi_crc32

Overview:
- PCPI responder (co-processor) on the `picorv32` PCPI port; executes custom-0 CRC32 update instructions issued by the core.
- Bit-serial, reflected (LSB-first) CRC32 engine; multi-cycle; holds `pcpi_wait` while computing, then returns the result with a one-cycle `pcpi_ready`/`pcpi_wr` pulse.
- Instantiated next to the core in the SoC top alongside the FPU; claims only its own encodings and never responds to other instructions.

Parameters:
- POLY, 32'hEDB88320, reflected CRC polynomial.
- BITS_PER_CYCLE, 1, bits consumed per BUSY cycle; legal values 1, 2, 4, 8.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- pcpi_valid  input  1  core presents an instruction; held until the core samples pcpi_ready
- pcpi_insn  input  32  instruction word
- pcpi_rs1  input  32  current CRC value
- pcpi_rs2  input  32  data; low 8/16/32 bits used
- pcpi_wr  output  1  write result to rd; high only with pcpi_ready
- pcpi_rd  output  32  result; valid only when pcpi_ready is high, 0 otherwise
- pcpi_wait  output  1  instruction claimed and executing
- pcpi_ready  output  1  one-cycle completion strobe

Behaviour:
- Reset is asynchronous, active-high. It sets the state to IDLE and drives pcpi_wr, pcpi_rd, pcpi_wait and pcpi_ready to 0.
- Decode: match when insn[6:0]=7'b0001011, insn[31:25]=7'b0000000, and funct3 is one of:
  - 000: byte, NBITS=8
  - 001: half, NBITS=16
  - 010: word, NBITS=32
- Any other encoding is not claimed: all outputs stay 0, and the core times out or traps on its own.
- Bit step, for i=0..NBITS-1 in LSB-first order: fb = crc[0]^data[i]; crc = (crc>>1) ^ (fb ? POLY : 0). There is no init or final inversion; software handles both.
- FSM IDLE:
  - Stay in IDLE unless pcpi_valid is high and the decode matches.
  - On a match: latch rs1 into crc, latch rs2 into the data shift register, set cnt = NBITS/BITS_PER_CYCLE, and go to BUSY.
- FSM BUSY:
  - pcpi_wait=1.
  - Each cycle: apply BITS_PER_CYCLE bit steps, shift data right by BITS_PER_CYCLE, decrement cnt.
  - When cnt reaches 1 with this cycle's step, go to DONE.
- FSM DONE:
  - pcpi_ready=1, pcpi_wr=1, pcpi_rd=crc, pcpi_wait=0 for exactly one cycle, then IDLE.
- Latency, taking the accept edge as edge 0:
  - pcpi_wait is high during cycles 1..N, where N = NBITS/BITS_PER_CYCLE.
  - pcpi_ready is high in cycle N+1.
  - Example, byte op with BITS_PER_CYCLE=1: ready 9 cycles after accept.
- Rs1/rs2 are sampled only at accept. Later changes on those inputs are ignored.
- Abort: if pcpi_valid falls while in BUSY, go to IDLE next edge with no ready pulse and discard the result.
- Back-to-back: the cycle after DONE is IDLE. A new pcpi_valid seen in IDLE is accepted. The responder never re-accepts during DONE.
- Reset mid-BUSY or in DONE: outputs drop to 0 immediately and no ready pulse is issued.
- Outputs are all registered; no combinational path from inputs to outputs.

Decomposition:
- Package pcpi_crc32_pkg holds:
  - OPC_CUSTOM0 = 7'b0001011
  - FUNCT7_CRC = 7'b0000000
  - FUNCT3_CRC_B/H/W = 3'b000/001/010
  - state enum {IDLE, BUSY, DONE}
  - CRC32_POLY_REFLECTED default
- Sub-module crc32_bit_step: combinational, parameterised by POLY and BITS_PER_CYCLE. Inputs crc[31:0] and data[BITS_PER_CYCLE-1:0]; output crc_next.

Test Plan:
- Byte op, rs1=32'h00000000, rs2=32'h00000001, funct3=000 -> pcpi_rd=32'h77073096 with wr=1, ready in cycle 9 (BITS_PER_CYCLE=1), wait high cycles 1..8.
- Byte op, rs1=32'hFFFFFFFF, rs2=32'h00000061 ('a') -> pcpi_rd=32'h174841BC (inverted gives 32'hE8B7BE43).
- Half/word ops, rs1=0, rs2=0 -> pcpi_rd=0, ready in cycles 17 and 33 respectively. Repeat the word op with BITS_PER_CYCLE=8 -> ready in cycle 5.
- Unclaimed insn: funct3=011, or opcode 7'b0110011 (MUL) -> wait/ready/wr stay 0 for 20 cycles.
- Abort and reset: drop pcpi_valid at BUSY cycle 3 -> no ready pulse, IDLE, and the next valid byte op (rs1=0, rs2=1) returns 32'h77073096. Assert reset in BUSY cycle 4 -> all outputs 0 in the same cycle.
- Back-to-back: two byte ops, re-asserting valid the cycle after ready -> two distinct ready pulses with correct results, and rs1/rs2 toggled during BUSY have no effect.
